// File: rtl/theta_col_stage.sv
// Keccak theta column stage: buffers 25 lanes, forms column parities, emits theta-mixed lanes.
// Latency: CALC one cycle after lane 24 is accepted, first output the cycle after that; done pulses after idx 24.
// Backpressure: in_ready only in LOAD; outputs hold while out_ready=0. `COL_PARITY_PORT_EN adds col_par.
module theta_col_stage #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init0,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_lane,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_lane,
    output logic [4:0]     out_idx,
    output logic           done
`ifdef COL_PARITY_PORT_EN
    ,
    output logic [5*W-1:0] col_par
`endif
);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]   state;
    logic [4:0]   in_cnt;
    logic [4:0]   out_cnt;
    // x coordinates tracked alongside the counts so no modulo-5 logic is needed
    logic [2:0]   in_x;
    logic [2:0]   out_x;
    logic [W-1:0] lane_buf [25];
    logic [W-1:0] c [5];
    logic [W-1:0] d [5];
    logic         in_fire;
    logic         out_fire;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign in_fire   = in_ready && in_valid;
    assign out_fire  = out_valid && out_ready;
    assign out_idx   = out_cnt;
    assign out_lane  = lane_buf[out_cnt] ^ d[out_x];

`ifdef COL_PARITY_PORT_EN
    assign col_par = {c[4], c[3], c[2], c[1], c[0]};
`endif

    always_ff @(posedge clk) begin
        if (in_fire) begin
            lane_buf[in_cnt] <= in_lane;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            in_cnt  <= 5'd0;
            out_cnt <= 5'd0;
            in_x    <= 3'd0;
            out_x   <= 3'd0;
            done    <= 1'b0;
            for (int x = 0; x < 5; x++) begin
                c[x] <= '0;
                d[x] <= '0;
            end
        end else if (init0) begin
            state   <= LOAD;
            in_cnt  <= 5'd0;
            out_cnt <= 5'd0;
            in_x    <= 3'd0;
            out_x   <= 3'd0;
            done    <= 1'b0;
            for (int x = 0; x < 5; x++) begin
                c[x] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        c[in_x] <= c[in_x] ^ in_lane;
                        in_x    <= (in_x == 3'd4) ? 3'd0 : in_x + 3'd1;
                        if (in_cnt == 5'd24) begin
                            in_cnt <= 5'd0;
                            state  <= CALC;
                        end else begin
                            in_cnt <= in_cnt + 5'd1;
                        end
                    end
                end
                CALC: begin
                    for (int x = 0; x < 5; x++) begin
                        d[x] <= c[(x + 4) % 5] ^ {c[(x + 1) % 5][W-2:0], c[(x + 1) % 5][W-1]};
                    end
                    state <= EMIT;
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_cnt == 5'd24) begin
                            out_cnt <= 5'd0;
                            out_x   <= 3'd0;
                            in_cnt  <= 5'd0;
                            in_x    <= 3'd0;
                            done    <= 1'b1;
                            state   <= LOAD;
                            for (int x = 0; x < 5; x++) begin
                                c[x] <= '0;
                            end
                        end else begin
                            out_cnt <= out_cnt + 5'd1;
                            out_x   <= (out_x == 3'd4) ? 3'd0 : out_x + 3'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
